// File: rtl/lcd_text_buffer.sv
// 2x16 character frame buffer feeding the SC1602 LCD driver.
// Terminal-style write stream with cursor, wrap and clear sequences.
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter bit         LF_CLEARS = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  input  logic [7:0] rd_addr,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       cur_line,
  output logic [3:0] cur_col,
  output logic       busy
);

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    CLR_ALL,
    CLR_LINE
  } state_t;

  state_t     state, state_n;
  logic [4:0] idx, idx_n;
  logic       line_n;
  logic [3:0] col_n;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [7:0] mem [32];
  logic       xfer;
  logic       printable;
  logic       rd_unused;

  assign rd_unused = rd;
  assign xfer      = ch_valid & ch_ready;
  assign busy      = ~ch_ready;
  assign printable = (ch_data >= 8'h20 && ch_data <= 8'h7E)
                   || (ch_data >= 8'hA0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= INIT_CLR;
      idx      <= '0;
      cur_line <= 1'b0;
      cur_col  <= '0;
      ch_ready <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cur_line <= line_n;
      cur_col  <= col_n;
      ch_ready <= (state_n == IDLE);
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    line_n  = cur_line;
    col_n   = cur_col;
    we      = 1'b0;
    waddr   = {cur_line, cur_col};
    wdata   = FILL_CHAR;
    unique case (state)
      INIT_CLR, CLR_ALL: begin
        we    = 1'b1;
        waddr = idx;
        idx_n = idx + 5'd1;
        if (idx == 5'd31) begin
          state_n = IDLE;
          idx_n   = '0;
        end
      end
      CLR_LINE: begin
        we    = 1'b1;
        waddr = {cur_line, idx[3:0]};
        idx_n = idx + 5'd1;
        if (idx == 5'd15) begin
          state_n = IDLE;
          idx_n   = '0;
        end
      end
      IDLE: begin
        if (xfer) begin
          unique case (1'b1)
            printable: begin
              we    = 1'b1;
              wdata = ch_data;
              col_n = cur_col + 4'd1;
              if (cur_col == 4'd15)
                line_n = ~cur_line;
            end
            ch_data == 8'h0D: col_n = '0;
            ch_data == 8'h0A: begin
              line_n = ~cur_line;
              col_n  = '0;
              if (LF_CLEARS) begin
                state_n = CLR_LINE;
                idx_n   = '0;
              end
            end
            ch_data == 8'h08: begin
              // Backspace stops at column 0; no reverse line wrap.
              if (cur_col != 4'd0) begin
                col_n = cur_col - 4'd1;
                we    = 1'b1;
                waddr = {cur_line, cur_col - 4'd1};
              end
            end
            ch_data == 8'h0C: begin
              state_n = CLR_ALL;
              idx_n   = '0;
              line_n  = 1'b0;
              col_n   = '0;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_comb begin
    rd_data = FILL_CHAR;
    if (!rd_addr[7] && rd_addr[5:4] == 2'b00)
      rd_data = mem[{rd_addr[6], rd_addr[3:0]}];
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer.
// Hand-computed expectations for cursor, wrap, control codes and clears.
module tb_lcd_text_buffer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;
  logic [7:0] rd_addr;
  logic       rd;
  logic [7:0] rd_data;
  logic       cur_line;
  logic [3:0] cur_col;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_text_buffer dut (
    .clk      (clk),
    .resetn   (resetn),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .rd_addr  (rd_addr),
    .rd       (rd),
    .rd_data  (rd_data),
    .cur_line (cur_line),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [7:0] a,
                       input logic [7:0] e);
    rd_addr = a;
    #1;
    chk(tag, {24'h0, rd_data}, {24'h0, e});
  endtask

  task automatic cur_chk(input string tag, input logic l,
                         input logic [3:0] c);
    chk({tag, "_line"}, {31'h0, cur_line}, {31'h0, l});
    chk({tag, "_col"}, {28'h0, cur_col}, {28'h0, c});
  endtask

  // Holds ch_valid until accepted; waits = edges spent with ch_ready low.
  task automatic send(input logic [7:0] c, output int waits);
    logic r;
    waits = 0;
    @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = c;
    do begin
      r = ch_ready;
      @(posedge clk);
      #1;
      if (!r) waits++;
    end while (!r && waits < 200);
    ch_valid = 1'b0;
    if (waits >= 200) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ch_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n, w;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    resetn = 1'b0; ch_valid = 1'b0; ch_data = '0;
    rd_addr = '0; rd = 1'b0;

    #12;
    chk("rst_ready", {31'h0, ch_ready}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd1);
    cur_chk("rst", 1'b0, 4'd0);
    @(negedge clk);
    resetn = 1'b1;
    wait_ready(n);
    chk("init_cycles", n, 32);
    for (int a = 0; a < 16; a++) begin
      rdchk($sformatf("init_l0_%0d", a), 8'(a), 8'h20);
      rdchk($sformatf("init_l1_%0d", a), 8'(8'h40 + a), 8'h20);
    end
    rdchk("init_0x10", 8'h10, 8'h20);
    rdchk("init_0x80", 8'h80, 8'h20);

    for (int i = 0; i < 5; i++) begin
      send(hello[i], w);
      chk("hello_ready", {31'h0, ch_ready}, 32'd1);
    end
    for (int i = 0; i < 5; i++)
      rdchk($sformatf("hello_%0d", i), 8'(i), hello[i]);
    cur_chk("hello", 1'b0, 4'd5);
    rdchk("alias_0x10", 8'h10, 8'h20);
    rdchk("alias_0x80", 8'h80, 8'h20);
    rdchk("alias_0xA0", 8'hA0, 8'h20);

    send(8'h0C, w);
    chk("ff1_ready_low", {31'h0, ch_ready}, 32'd0);
    cur_chk("ff1", 1'b0, 4'd0);
    wait_ready(n);
    chk("ff1_cycles", n, 32);
    rdchk("ff1_0x00", 8'h00, 8'h20);

    for (int i = 0; i < 17; i++) send(8'(8'h41 + i), w);
    for (int i = 0; i < 16; i++)
      rdchk($sformatf("wrap_l0_%0d", i), 8'(i), 8'(8'h41 + i));
    rdchk("wrap_0x40", 8'h40, 8'h51);
    cur_chk("wrap17", 1'b1, 4'd1);
    for (int i = 0; i < 15; i++) send(8'(8'h61 + i), w);
    cur_chk("wrap32", 1'b0, 4'd0);
    rdchk("wrap_0x41", 8'h41, 8'h61);
    rdchk("wrap_0x4f", 8'h4F, 8'h6F);

    send(8'h0A, w);
    wait_ready(n);
    chk("lf1_cycles", n, 16);
    cur_chk("lf1", 1'b1, 4'd0);
    for (int i = 0; i < 16; i++) send(8'h58, w);
    rdchk("xfill_0x45", 8'h45, 8'h58);
    cur_chk("xfill", 1'b0, 4'd0);
    send(8'h68, w); send(8'h69, w); send(8'h6A, w);
    cur_chk("pre_lf", 1'b0, 4'd3);
    send(8'h0A, w);
    chk("lf2_ready_low", {31'h0, ch_ready}, 32'd0);
    wait_ready(n);
    chk("lf2_cycles", n, 16);
    for (int i = 0; i < 16; i++)
      rdchk($sformatf("lf2_l1_%0d", i), 8'(8'h40 + i), 8'h20);
    rdchk("lf2_0x00", 8'h00, 8'h68);
    rdchk("lf2_0x03", 8'h03, 8'h44);
    rdchk("lf2_0x0f", 8'h0F, 8'h50);
    cur_chk("lf2", 1'b1, 4'd0);

    send(8'h08, w);
    cur_chk("bs_l1c0", 1'b1, 4'd0);
    chk("bs_ready", {31'h0, ch_ready}, 32'd1);
    send(8'h01, w);
    cur_chk("ignored", 1'b1, 4'd0);
    chk("ignored_ready", {31'h0, ch_ready}, 32'd1);
    send(8'h72, w);
    rdchk("r_0x40", 8'h40, 8'h72);
    cur_chk("r", 1'b1, 4'd1);
    send(8'h0D, w);
    cur_chk("cr", 1'b1, 4'd0);
    rdchk("cr_0x41", 8'h41, 8'h20);

    send(8'h0A, w);
    wait_ready(n);
    chk("lf3_cycles", n, 16);
    rdchk("lf3_0x00", 8'h00, 8'h20);
    cur_chk("lf3", 1'b0, 4'd0);
    send(8'h08, w);
    cur_chk("bs_noop", 1'b0, 4'd0);
    send(8'h5A, w);
    rdchk("z_0x00", 8'h00, 8'h5A);
    cur_chk("z", 1'b0, 4'd1);
    send(8'h08, w);
    rdchk("bs_0x00", 8'h00, 8'h20);
    cur_chk("bs", 1'b0, 4'd0);

    send(8'h51, w);
    send(8'h0C, w);
    send(8'h57, w);
    chk("ff2_hold_wait", w, 32);
    rdchk("ff2_0x00", 8'h00, 8'h57);
    for (int i = 1; i < 16; i++)
      rdchk($sformatf("ff2_l0_%0d", i), 8'(i), 8'h20);
    for (int i = 0; i < 16; i++)
      rdchk($sformatf("ff2_l1_%0d", i), 8'(8'h40 + i), 8'h20);
    cur_chk("ff2", 1'b0, 4'd1);

    send(8'h62, w);
    rd_addr = 8'h02;
    @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = 8'h4B;
    #1;
    chk("rdw_old", {24'h0, rd_data}, 32'h20);
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    chk("rdw_new", {24'h0, rd_data}, 32'h4B);
    cur_chk("rdw", 1'b0, 4'd3);

    send(8'h0C, w);
    repeat (5) @(posedge clk);
    #1;
    chk("midclr_busy", {31'h0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst2_ready", {31'h0, ch_ready}, 32'd0);
    chk("rst2_busy", {31'h0, busy}, 32'd1);
    cur_chk("rst2", 1'b0, 4'd0);
    @(negedge clk);
    resetn = 1'b1;
    wait_ready(n);
    chk("rst2_init_cycles", n, 32);
    rdchk("rst2_0x00", 8'h00, 8'h20);
    rdchk("rst2_0x02", 8'h02, 8'h20);
    rdchk("rst2_0x4f", 8'h4F, 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
